// File: rtl/layer_sequencer.sv
// Layer sequencer: issues M neuron computations to the MAC controller, rescales each
// final accumulator (shift, ReLU, unsigned saturation) and holds the activations for the next layer.
module layer_sequencer #(
    parameter int M     = 8,
    parameter int IDX_W = 3,
    parameter int ACC_W = 32,
    parameter int SHIFT = 8,
    parameter int OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    ip_ready,
    input  logic signed [ACC_W-1:0] acc_in,
    input  logic [IDX_W-1:0]        rd_addr,
    output logic                    ip_start,
    output logic [IDX_W-1:0]        neuron_sel,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_W-1:0]        rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(M - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sel_q, sel_nxt;
    logic [OUT_W-1:0] act_mem [M];
    logic             wr_vld_p0;
    logic [OUT_W-1:0] act_p0;
    logic [OUT_W-1:0] rd_mux_p0;
    logic [OUT_W-1:0] rd_data_p1;

    // Negative results clamp to zero; anything above the OUT_W range clamps to full scale.
    function automatic logic [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] s;
        s = x >>> SHIFT;
        if (s < 0)
            return '0;
        if (|s[ACC_W-2:OUT_W])
            return '1;
        return s[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
        end
    end

    // WAIT_LO exists so the still-high ready of the issue cycle is never taken as completion.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        ip_start  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_vld_p0 = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    sel_nxt   = '0;
                end
            end
            ISSUE: begin
                busy = 1'b1;
                if (ip_ready) begin
                    ip_start  = 1'b1;
                    state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                busy = 1'b1;
                if (!ip_ready)
                    state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                busy = 1'b1;
                if (ip_ready)
                    state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy      = 1'b1;
                wr_vld_p0 = 1'b1;
                if (sel_q == LAST_SEL) begin
                    state_nxt = DONE;
                end else begin
                    sel_nxt   = sel_q + IDX_W'(1);
                    state_nxt = ISSUE;
                end
            end
            DONE: begin
                done      = 1'b1;
                sel_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: activation of the settled accumulator, written in CAPTURE
    assign act_p0 = relu_sat(acc_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++)
                act_mem[i] <= '0;
        end else if (wr_vld_p0) begin
            for (int i = 0; i < M; i++)
                if (sel_q == IDX_W'(i))
                    act_mem[i] <= act_p0;
        end
    end

    // Addresses at or beyond M match no entry and read as zero.
    always_comb begin
        rd_mux_p0 = '0;
        for (int i = 0; i < M; i++)
            if (rd_addr == IDX_W'(i))
                rd_mux_p0 = act_mem[i];
    end

    // Stage p1: registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data_p1 <= '0;
        else
            rd_data_p1 <= rd_mux_p0;
    end

    assign rd_data    = rd_data_p1;
    assign neuron_sel = sel_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: behavioural neuron controller, read-port scoreboard,
// activation vector table and hand-written stall / ignored-start / reset / read-collision sequences.
module tb_layer_sequencer;

    localparam int M     = 8;
    localparam int IDX_W = 4;
    localparam int ACC_W = 32;
    localparam int SHIFT = 8;
    localparam int OUT_W = 8;
    localparam int N     = 10;
    localparam int NOM   = M * (N + 4) + 1;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    ip_ready;
    logic signed [ACC_W-1:0] acc_in;
    logic [IDX_W-1:0]        rd_addr;
    logic                    ip_start;
    logic [IDX_W-1:0]        neuron_sel;
    logic                    busy;
    logic                    done;
    logic [OUT_W-1:0]        rd_data;

    layer_sequencer #(
        .M(M), .IDX_W(IDX_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ip_ready(ip_ready), .acc_in(acc_in),
        .rd_addr(rd_addr), .ip_start(ip_start), .neuron_sel(neuron_sel), .busy(busy),
        .done(done), .rd_data(rd_data)
    );

    typedef struct {
        logic [IDX_W-1:0] addr;
        logic [OUT_W-1:0] exp;
        int               due;
    } rd_t;

    typedef struct {
        logic signed [ACC_W-1:0] acc;
        logic [OUT_W-1:0]        exp;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int pulses = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_rise_idx = -1;
    int stall_at = -1;
    int lay_c0, lay_p0, lay_d0;
    logic signed [ACC_W-1:0] acc_tab [M];
    int exp_buf [16];
    rd_t sb[$];
    vec_t vecs [M];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: ip_start pulses, done pulses, reset behaviour and read-port scoreboard
    initial begin : monitor
        rd_t e;
        forever begin
            @(negedge clk);
            if (ip_start) pulses++;
            if (rst) check("no_ip_start_in_rst", ip_start, 0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_low_with_done", busy, 0);
            end
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check($sformatf("rd_data[%0d]", e.addr), rd_data, e.exp);
            end
        end
    end

    // Neuron controller model: N+2 cycles busy per computation, optional ready stall before one issue
    initial begin : neuron_model
        int lo_cnt, stall_cnt, cur;
        bit fire, stall_arm;
        logic [IDX_W-1:0] sel_s;
        lo_cnt = 0; stall_cnt = 0; cur = 0; stall_arm = 0;
        ip_ready = 1'b1;
        acc_in = '0;
        forever begin
            @(negedge clk);
            fire = ip_start;
            sel_s = neuron_sel;
            if (stall_cnt > 0 && stall_cnt <= 5) begin
                check("sel_stable_in_stall", neuron_sel, stall_at);
                check("no_start_in_stall", ip_start, 0);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                lo_cnt = 0; stall_cnt = 0; stall_arm = 0;
                ip_ready = 1'b1;
            end else if (fire) begin
                ip_ready = 1'b0;
                lo_cnt = N + 1;
                cur = int'(sel_s);
                acc_in = $urandom;
            end else if (lo_cnt > 0) begin
                lo_cnt--;
                if (lo_cnt == 0) begin
                    ip_ready = 1'b1;
                    acc_in = acc_tab[cur];
                    last_rise_idx = cur;
                    if (cur + 1 == stall_at) stall_arm = 1'b1;
                end
            end else if (stall_arm) begin
                stall_arm = 1'b0;
                ip_ready = 1'b0;
                stall_cnt = 6;
            end else if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) ip_ready = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_req(input int addr, input int exp);
        rd_t e;
        rd_addr = IDX_W'(addr);
        e.addr = IDX_W'(addr);
        e.exp = OUT_W'(exp);
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic read_back();
        for (int a = 0; a < 16; a++) begin
            rd_req(a, exp_buf[a]);
            tick();
        end
        tick();
    endtask

    task automatic begin_layer();
        lay_d0 = done_cnt;
        lay_p0 = pulses;
        last_rise_idx = -1;
        start = 1'b1;
        lay_c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rise(input int idx);
        int t = 0;
        while (last_rise_idx != idx && t < 500) begin
            tick();
            t++;
        end
        check($sformatf("ready_return_n%0d", idx), last_rise_idx, idx);
    endtask

    task automatic finish_layer(input string tag, input int exp_cycles);
        int t = 0;
        while (done_cnt == lay_d0 && t < 3000) begin
            tick();
            t++;
        end
        check({tag, "_done_once"}, done_cnt - lay_d0, 1);
        check({tag, "_ip_start_count"}, pulses - lay_p0, M);
        check({tag, "_latency"}, done_cyc - lay_c0, exp_cycles);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_sel_idle"}, neuron_sel, 0);
    endtask

    task automatic set_lin(input int mul, input int off);
        for (int k = 0; k < 16; k++) exp_buf[k] = 0;
        for (int k = 0; k < M; k++) begin
            acc_tab[k] = ACC_W'((k * mul + off) * 256);
            exp_buf[k] = k * mul + off;
        end
    endtask

    initial begin : main
        vecs[0] = '{32'shFFFF_FFFF, 8'd0};
        vecs[1] = '{32'sh0000_FF80, 8'd255};
        vecs[2] = '{32'sh0001_0000, 8'd255};
        vecs[3] = '{32'sh7FFF_FFFF, 8'd255};
        vecs[4] = '{32'sh0000_0180, 8'd1};
        vecs[5] = '{32'sh8000_0000, 8'd0};
        vecs[6] = '{32'sh0000_00FF, 8'd0};
        vecs[7] = '{32'sh0000_7F00, 8'd127};

        rst = 1'b0; start = 1'b0; rd_addr = '0;
        for (int k = 0; k < M; k++) acc_tab[k] = '0;
        #1 rst = 1'b1;
        tick();
        check("rst_ip_start", ip_start, 0);
        check("rst_neuron_sel", neuron_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        tick();

        // Nominal layer: acc = k*512 -> activation 2k
        set_lin(2, 0);
        begin_layer();
        check("busy_after_start", busy, 1);
        finish_layer("nominal", NOM);
        read_back();

        // Activation vector table: ReLU, saturation and rounding-by-truncation cases
        for (int k = 0; k < 16; k++) exp_buf[k] = 0;
        for (int k = 0; k < M; k++) begin
            acc_tab[k] = vecs[k].acc;
            exp_buf[k] = int'(vecs[k].exp);
        end
        begin_layer();
        finish_layer("act_table", NOM);
        read_back();

        // Ready held low for 5 cycles while neuron 2 is being issued
        set_lin(1, 10);
        stall_at = 2;
        begin_layer();
        finish_layer("ready_stall", NOM + 5);
        stall_at = -1;
        read_back();

        // start pulsed during WAIT_HI of neuron 3 is ignored
        set_lin(3, 1);
        begin_layer();
        wait_rise(2);
        while (pulses - lay_p0 < 4) tick();
        tick(); tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_layer("start_ignored", NOM);
        for (int i = 0; i < 20; i++) tick();
        check("start_ignored_no_extra_done", done_cnt - lay_d0, 1);
        check("start_ignored_no_extra_issue", pulses - lay_p0, M);
        check("start_ignored_idle_busy", busy, 0);
        read_back();

        // Reset during CAPTURE of neuron 5 clears everything
        set_lin(5, 2);
        begin_layer();
        wait_rise(5);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_busy_now", busy, 0);
        check("midrst_sel_now", neuron_sel, 0);
        check("midrst_done_now", done, 0);
        tick();
        check("midrst_busy_next", busy, 0);
        check("midrst_sel_next", neuron_sel, 0);
        check("midrst_rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) exp_buf[k] = 0;
        read_back();
        set_lin(2, 0);
        begin_layer();
        finish_layer("after_reset", NOM);
        read_back();

        // Read of address 4 in the same cycle it is written: old value, then new
        set_lin(1, 100);
        begin_layer();
        wait_rise(4);
        tick();
        rd_req(4, 8);
        tick();
        rd_req(4, 104);
        tick();
        finish_layer("rd_collision", NOM);
        read_back();

        tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
